// File: rtl/occupancy_pkg.sv
// Shared definitions for the occupancy tracker.
//   lane_state_e : 3-bit per-lane passage state encoding
//                  IDLE=0, EN1..EN3=1..3, EX1..EX3=4..6
//   net_w()      : width of the signed per-cycle net entry/exit delta
package occupancy_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    EN1  = 3'd1,
    EN2  = 3'd2,
    EN3  = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6
  } lane_state_e;

  // popcount of LANES bits needs $clog2(LANES+1) bits; one more for the sign
  function automatic int net_w(input int lanes);
    return $clog2(lanes + 1) + 1;
  endfunction

endpackage

// File: rtl/lane_direction_fsm.sv
// Single-lane direction detector.
// Synchronises the outer (a) and inner (b) sensors, tracks the four-phase
// passage sequence and emits a registered one-cycle pulse per completed
// entry or exit.
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   a, b        : raw outer / inner sensor, asynchronous to clk
//   enter_pulse : one-cycle pulse on a validated entry (a, ab, b, none)
//   exit_pulse  : one-cycle pulse on a validated exit  (b, ab, a, none)
module lane_direction_fsm
  import occupancy_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  output logic enter_pulse,
  output logic exit_pulse
);

  logic        a_p0, a_p1;
  logic        b_p0, b_p1;
  lane_state_e state;
  logic [1:0]  sab;

  // synchroniser output stage: {sa, sb}
  assign sab = {a_p1, b_p1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0        <= 1'b0;
      a_p1        <= 1'b0;
      b_p0        <= 1'b0;
      b_p1        <= 1'b0;
      state       <= IDLE;
      enter_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
    end else begin
      // stage p0 -> p1: two-flop synchroniser
      a_p0 <= a;
      a_p1 <= a_p0;
      b_p0 <= b;
      b_p1 <= b_p0;

      // stage p1 -> FSM: pulses default low, set only on completion
      enter_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          // simultaneous onset (2'b11) is ambiguous and ignored
          if (sab == 2'b10)      state <= EN1;
          else if (sab == 2'b01) state <= EX1;
        end
        EN1: begin
          if (sab == 2'b11)      state <= EN2;
          else if (sab != 2'b10) state <= IDLE;
        end
        EN2: begin
          if (sab == 2'b01)      state <= EN3;
          else if (sab == 2'b10) state <= EN1;
          else if (sab == 2'b00) state <= IDLE;
        end
        EN3: begin
          if (sab == 2'b00) begin
            state       <= IDLE;
            enter_pulse <= 1'b1;
          end else if (sab == 2'b11) state <= EN2;
          else if (sab == 2'b10)     state <= IDLE;
        end
        EX1: begin
          if (sab == 2'b11)      state <= EX2;
          else if (sab != 2'b01) state <= IDLE;
        end
        EX2: begin
          if (sab == 2'b10)      state <= EX3;
          else if (sab == 2'b01) state <= EX1;
          else if (sab == 2'b00) state <= IDLE;
        end
        EX3: begin
          if (sab == 2'b00) begin
            state      <= IDLE;
            exit_pulse <= 1'b1;
          end else if (sab == 2'b11) state <= EX2;
          else if (sab == 2'b01)     state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/occupancy_tracker.sv
// Multi-lane car-park occupancy tracker.
// One lane_direction_fsm per sensor pair; validated entries and exits from
// all lanes are merged each cycle into a count clamped to [0, CAPACITY].
//   clk           : rising-edge clock
//   rst_n         : asynchronous active-low reset
//   a, b          : per-lane outer / inner sensors (asynchronous)
//   clear         : synchronous count clear, overrides that cycle's pulses
//   count         : current occupancy
//   full / empty  : count == CAPACITY / count == 0
//   enter_pulse   : per-lane one-cycle validated entry
//   exit_pulse    : per-lane one-cycle validated exit
//   overflow_err  : one-cycle pulse when an increment was clipped
//   underflow_err : one-cycle pulse when a decrement was clipped
module occupancy_tracker
  import occupancy_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int CNT_W    = 8,
  parameter int CAPACITY = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic [LANES-1:0] enter_pulse,
  output logic [LANES-1:0] exit_pulse,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int NET_W = net_w(LANES);
  localparam int SUM_W = CNT_W + 2;
  localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

  if (CAPACITY <= 0 || CAPACITY >= (1 << CNT_W)) begin : g_cap_illegal
    $error("occupancy_tracker: CAPACITY must satisfy 0 < CAPACITY < 2**CNT_W");
  end
  if (LANES < 1 || LANES > 8) begin : g_lanes_illegal
    $error("occupancy_tracker: LANES must be in 1..8");
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_direction_fsm u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .a           (a[i]),
      .b           (b[i]),
      .enter_pulse (enter_pulse[i]),
      .exit_pulse  (exit_pulse[i])
    );
  end

  function automatic logic [NET_W-1:0] popcnt(input logic [LANES-1:0] v);
    logic [NET_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + NET_W'(v[i]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_count(input logic signed [SUM_W-1:0] v);
    if (v > CAP_S)    return CNT_W'(CAPACITY);
    else if (v < 0)   return '0;
    else              return v[CNT_W-1:0];
  endfunction

  logic signed [NET_W-1:0] net_p0;
  logic signed [SUM_W-1:0] sum_p0;

  // stage p0: lane pulses -> signed net delta -> unclamped next count
  // popcounts never reach the sign bit, so both operands are non-negative
  assign net_p0 = signed'(popcnt(enter_pulse)) - signed'(popcnt(exit_pulse));
  assign sum_p0 = signed'({2'b00, count}) + SUM_W'(net_p0);

  // stage p0 -> count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (clear) begin
      count         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      count         <= sat_count(sum_p0);
      overflow_err  <= (sum_p0 > CAP_S);
      underflow_err <= (sum_p0 < 0);
    end
  end

  assign full  = (count == CNT_W'(CAPACITY));
  assign empty = (count == '0);

endmodule

// File: tb/tb_occupancy_tracker.sv
// Directed bench for occupancy_tracker (LANES=2, CNT_W=8, CAPACITY=6).
module tb_occupancy_tracker;

  logic       clk;
  logic       rst_n;
  logic [1:0] a, b;
  logic       clear;
  logic [7:0] count;
  logic       full, empty;
  logic [1:0] enter_pulse, exit_pulse;
  logic       overflow_err, underflow_err;

  int tests  = 0;
  int failed = 0;
  int enter_cnt[2] = '{0, 0};
  int exit_cnt[2]  = '{0, 0};
  int ovf_cnt = 0;
  int unf_cnt = 0;

  occupancy_tracker #(.LANES(2), .CNT_W(8), .CAPACITY(6)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .a             (a),
    .b             (b),
    .clear         (clear),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .enter_pulse   (enter_pulse),
    .exit_pulse    (exit_pulse),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tally pulses on the falling edge, away from the update edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (enter_pulse[i]) enter_cnt[i]++;
      if (exit_pulse[i])  exit_cnt[i]++;
    end
    if (overflow_err)  ovf_cnt++;
    if (underflow_err) unf_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // entry lanes see a, ab, b, none; exit lanes see b, ab, a, none
  task automatic passage(input logic [1:0] en, input logic [1:0] ex, input int tail);
    a = en;      b = ex;      cyc(4);
    a = en | ex; b = en | ex; cyc(4);
    a = ex;      b = en;      cyc(4);
    a = 2'b00;   b = 2'b00;   cyc(tail);
  endtask

  initial begin
    rst_n = 1'b1; a = 2'b00; b = 2'b00; clear = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full, 0);
    chk("rst_pulses", {enter_pulse, exit_pulse}, 0);
    chk("rst_errs", {overflow_err, underflow_err}, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // lane 0 entry with latency check
    passage(2'b01, 2'b00, 3);
    chk("entry_pulse_n2", enter_pulse, 1);
    chk("entry_count_n2", count, 0);
    cyc(1);
    chk("entry_count_n3", count, 1);
    chk("entry_empty", empty, 0);
    chk("entry_pulse_gone", enter_pulse, 0);

    // lane 1 aborted entry: a, ab, a, none
    a = 2'b10; b = 2'b00; cyc(4);
    a = 2'b10; b = 2'b10; cyc(4);
    a = 2'b10; b = 2'b00; cyc(4);
    a = 2'b00; b = 2'b00; cyc(6);
    chk("abort_count", count, 1);
    chk("abort_enter1", enter_cnt[1], 0);
    chk("abort_exit1", exit_cnt[1], 0);

    // lane 0 exit from count 1
    passage(2'b00, 2'b01, 5);
    chk("exit_cnt0", exit_cnt[0], 1);
    chk("exit_count", count, 0);
    chk("exit_empty", empty, 1);

    // count 0: exit lane 0 and entry lane 1 together, net 0
    passage(2'b10, 2'b01, 3);
    chk("mixed_enter", enter_pulse, 2'b10);
    chk("mixed_exit", exit_pulse, 2'b01);
    cyc(2);
    chk("mixed_count", count, 0);
    chk("mixed_unf", unf_cnt, 0);

    // count 0: lone exit on lane 1
    passage(2'b00, 2'b10, 4);
    chk("under_pulse", underflow_err, 1);
    chk("under_count", count, 0);
    cyc(1);
    chk("under_once", unf_cnt, 1);

    // build to 5, then clear in the same cycle as an entry pulse
    passage(2'b11, 2'b00, 5);
    passage(2'b11, 2'b00, 5);
    passage(2'b01, 2'b00, 5);
    chk("build_count5", count, 5);
    passage(2'b10, 2'b00, 3);
    chk("clr_pulse_present", enter_pulse, 2'b10);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clr_count", count, 0);
    chk("clr_errs", {overflow_err, underflow_err}, 0);
    cyc(2);
    chk("clr_no_ovf", ovf_cnt, 0);
    chk("clr_count_hold", count, 0);

    // build to 5, then two simultaneous entries clip at 6
    passage(2'b11, 2'b00, 5);
    passage(2'b11, 2'b00, 5);
    passage(2'b01, 2'b00, 5);
    chk("build2_count5", count, 5);
    passage(2'b11, 2'b00, 4);
    chk("ovf_count", count, 6);
    chk("ovf_full", full, 1);
    chk("ovf_pulse", overflow_err, 1);
    cyc(1);
    chk("ovf_pulse_gone", overflow_err, 0);
    chk("ovf_once", ovf_cnt, 1);
    passage(2'b01, 2'b00, 5);
    chk("sat_count", count, 6);
    chk("sat_ovf", ovf_cnt, 2);
    chk("enter0_total", enter_cnt[0], 9);
    chk("enter1_total", enter_cnt[1], 7);

    // reset during EN2, released with ab held
    a = 2'b01; b = 2'b00; cyc(4);
    a = 2'b01; b = 2'b01; cyc(3);
    rst_n = 1'b0;
    #1;
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_full", full, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    a = 2'b00; b = 2'b01; cyc(4);
    a = 2'b00; b = 2'b00; cyc(6);
    chk("mrst_no_entry", enter_cnt[0], 9);
    chk("mrst_no_exit", exit_cnt[0], 2);
    chk("mrst_count_after", count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
